cpu_issue_ctrl: RTL and testbench

Instruction-issue controller placed in front of the single-cycle RV32 core. It buffers instructions from an upstream requester (testbench driver or loader) in a small FIFO and sequences the core through reset, run and drain. Each cycle it presents exactly one instruction, or a NOP bubble, and counts real issues.

---
 rtl/cpu_issue_ctrl.sv | 109 ++++++++++
 tb/tb_cpu_issue_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_issue_ctrl.sv
// Instruction-issue controller: buffers upstream words in a small FIFO and
// sequences the core through reset, run and drain, issuing one word or a NOP per cycle.
module cpu_issue_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter logic [31:0] NOP   = 32'h0000_0013,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt_req,
  input  logic             in_valid,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             cpu_rst,
  output logic [31:0]      cpu_instr,
  output logic             cpu_issue,
  output logic [CNT_W-1:0] issued_cnt,
  output logic             busy,
  output logic             done
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RESET,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state, state_nx;
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [OCC_W-1:0] occ;
  logic             push, pop;
  logic             cpu_rst_nx, cpu_issue_nx, busy_nx, done_nx;
  logic [31:0]      cpu_instr_nx;
  logic [CNT_W-1:0] cnt_nx;

  // in_ready is gated by rst so nothing is accepted while the block is held in reset
  assign in_ready = rst && (state != S_DRAIN) && (occ < OCC_W'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = ((state == S_RUN) || (state == S_DRAIN)) && (occ != '0);

  // Next state and next registered outputs; outputs follow the state being entered
  always_comb begin
    state_nx     = state;
    cpu_instr_nx = NOP;
    cpu_issue_nx = 1'b0;
    cnt_nx       = issued_cnt;
    cpu_rst_nx   = 1'b0;
    busy_nx      = 1'b0;
    done_nx      = 1'b0;

    case (state)
      S_IDLE, S_DONE: if (start) state_nx = S_RESET;
      S_RESET:        state_nx = S_RUN;
      S_RUN:          if (halt_req) state_nx = S_DRAIN;
      S_DRAIN:        if (!pop) state_nx = S_DONE;
      default:        state_nx = S_IDLE;
    endcase

    if (pop) begin
      cpu_instr_nx = mem[rd_ptr];
      cpu_issue_nx = 1'b1;
      cnt_nx       = issued_cnt + CNT_W'(1);
    end

    if (state_nx == S_RESET) cnt_nx = '0;
    cpu_rst_nx = (state_nx == S_RESET);
    busy_nx    = (state_nx == S_RESET) || (state_nx == S_RUN) || (state_nx == S_DRAIN);
    done_nx    = (state_nx == S_DONE);
  end

  // State, FIFO pointers and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      occ        <= '0;
      cpu_rst    <= 1'b1;
      cpu_instr  <= NOP;
      cpu_issue  <= 1'b0;
      issued_cnt <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_nx;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      occ        <= occ + OCC_W'(push) - OCC_W'(pop);
      cpu_rst    <= cpu_rst_nx;
      cpu_instr  <= cpu_instr_nx;
      cpu_issue  <= cpu_issue_nx;
      issued_cnt <= cnt_nx;
      busy       <= busy_nx;
      done       <= done_nx;
    end
  end

  // FIFO storage needs no reset; occupancy decides validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

endmodule

// File: tb/tb_cpu_issue_ctrl.sv
// Directed bench for cpu_issue_ctrl: queue-based reference model compared every
// cycle, plus hand-computed literal expectations along each scenario.
module tb_cpu_issue_ctrl;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start, halt_req, in_valid;
  logic [31:0]      in_instr;
  logic             in_ready, cpu_rst, cpu_issue, busy, done;
  logic [31:0]      cpu_instr;
  logic [CNT_W-1:0] issued_cnt;

  int vectors = 0;
  int miscompares = 0;

  cpu_issue_ctrl #(.DEPTH(DEPTH), .NOP(NOP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start), .halt_req(halt_req),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .cpu_rst(cpu_rst), .cpu_instr(cpu_instr), .cpu_issue(cpu_issue),
    .issued_cnt(issued_cnt), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase of the run, FIFO as a queue, expected registered outputs
  typedef enum int {P_IDLE, P_RESET, P_RUN, P_DRAIN, P_DONE} phase_t;
  phase_t           ph = P_IDLE;
  logic [31:0]      q[$];
  logic             e_rst = 1'b1;
  logic             e_issue = 1'b0;
  logic [31:0]      e_instr = NOP;
  logic [CNT_W-1:0] e_cnt = '0;

  function automatic bit m_ready();
    return (rst === 1'b1) && (ph != P_DRAIN) && (q.size() < int'(DEPTH));
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.delete();
      ph      = P_IDLE;
      e_rst   = 1'b1;
      e_instr = NOP;
      e_issue = 1'b0;
      e_cnt   = '0;
    end else begin
      bit acc;
      acc     = (in_valid === 1'b1) && m_ready();
      e_rst   = 1'b0;
      e_instr = NOP;
      e_issue = 1'b0;
      case (ph)
        P_IDLE, P_DONE: if (start) begin ph = P_RESET; e_rst = 1'b1; e_cnt = '0; end
        P_RESET: ph = P_RUN;
        default: begin
          if (q.size() > 0) begin
            e_instr = q.pop_front();
            e_issue = 1'b1;
            e_cnt   = e_cnt + CNT_W'(1);
            if (ph == P_RUN && halt_req) ph = P_DRAIN;
          end else if (ph == P_DRAIN) ph = P_DONE;
          else if (halt_req) ph = P_DRAIN;
        end
      endcase
      if (acc) q.push_back(in_instr);
    end
  end

  // Compare every output against the model on the falling edge
  always @(negedge clk) begin
    chk("m_cpu_rst",   32'(cpu_rst),    32'(e_rst));
    chk("m_cpu_instr", cpu_instr,       e_instr);
    chk("m_cpu_issue", 32'(cpu_issue),  32'(e_issue));
    chk("m_cnt",       32'(issued_cnt), 32'(e_cnt));
    chk("m_busy",      32'(busy),       32'(ph == P_RESET || ph == P_RUN || ph == P_DRAIN));
    chk("m_done",      32'(done),       32'(ph == P_DONE));
    chk("m_in_ready",  32'(in_ready),   32'(m_ready()));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    in_valid = 1'b1;
    in_instr = w;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic end_run();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, guard;
    bit acc;
    start = 1'b0; halt_req = 1'b0; in_valid = 1'b0; in_instr = '0;
    #2 rst = 1'b0;
    repeat (2) tick();
    chk("rst_cpu_rst",  32'(cpu_rst),    32'd1);
    chk("rst_instr",    cpu_instr,       32'h0000_0013);
    chk("rst_issue",    32'(cpu_issue),  32'd0);
    chk("rst_cnt",      32'(issued_cnt), 32'd0);
    chk("rst_busy",     32'(busy),       32'd0);
    chk("rst_done",     32'(done),       32'd0);
    chk("rst_in_ready", 32'(in_ready),   32'd0);
    #1 rst = 1'b1;
    tick();
    chk("rel_cpu_rst",  32'(cpu_rst),    32'd0);

    // Preload two words in IDLE, then run
    push_word(32'h0050_0093);
    push_word(32'h00A0_0113);
    start = 1'b1; tick(); start = 1'b0;
    chk("t1_rst_hi",  32'(cpu_rst), 32'd1);
    chk("t1_busy",    32'(busy),    32'd1);
    tick();
    chk("t1_rst_lo",  32'(cpu_rst),   32'd0);
    chk("t1_nobub",   32'(cpu_issue), 32'd0);
    tick();
    chk("t1_w0",      cpu_instr,         32'h0050_0093);
    chk("t1_w0_iss",  32'(cpu_issue),    32'd1);
    tick();
    chk("t1_w1",      cpu_instr,         32'h00A0_0113);
    tick();
    chk("t1_nop",     cpu_instr,         32'h0000_0013);
    chk("t1_nop_iss", 32'(cpu_issue),    32'd0);
    chk("t1_cnt",     32'(issued_cnt),   32'd2);
    end_run();
    chk("t1_done",    32'(done), 32'd1);

    // Fill to full in DONE; extra word refused; ready returns after first pop
    for (int i = 0; i < 4; i++) push_word(32'h1000_0000 + 32'(i));
    chk("t2_full",    32'(in_ready), 32'd0);
    in_valid = 1'b1; in_instr = 32'hDEAD_BEEF;
    tick();
    chk("t2_full2",   32'(in_ready), 32'd0);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("t2_full_run", 32'(in_ready), 32'd0);
    tick();
    chk("t2_pop0",    cpu_instr,      32'h1000_0000);
    chk("t2_ready",   32'(in_ready),  32'd1);
    in_valid = 1'b0;
    tick();

    // Push and pop every cycle at occupancy 2
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1;
      in_instr = 32'h2000_0000 + 32'(i);
      tick();
      chk("t3_issue", 32'(cpu_issue), 32'd1);
      chk("t3_order", cpu_instr, (i < 2) ? 32'h1000_0002 + 32'(i) : 32'h2000_0000 + 32'(i - 2));
      chk("t3_ready", 32'(in_ready),  32'd1);
    end
    in_valid = 1'b0;
    repeat (3) tick();
    chk("t3_cnt",     32'(issued_cnt), 32'd14);
    end_run();

    // Drain with three words queued
    for (int i = 0; i < 3; i++) push_word(32'h3000_0000 + 32'(i));
    start = 1'b1; tick(); start = 1'b0;
    tick();
    halt_req = 1'b1; tick(); halt_req = 1'b0;
    chk("t4_d0",      cpu_instr,     32'h3000_0000);
    chk("t4_ready",   32'(in_ready), 32'd0);
    in_valid = 1'b1; in_instr = 32'hBAD0_0001;
    tick();
    chk("t4_d1",      cpu_instr,     32'h3000_0001);
    in_valid = 1'b0;
    tick();
    chk("t4_d2",      cpu_instr,     32'h3000_0002);
    tick();
    chk("t4_done",    32'(done),       32'd1);
    chk("t4_busy",    32'(busy),       32'd0);
    chk("t4_nop",     cpu_instr,       32'h0000_0013);
    chk("t4_cnt",     32'(issued_cnt), 32'd3);

    // 17 issues through a 4-bit counter, pointers wrapping several times
    sent = 0;
    for (int i = 0; i < 4; i++) begin push_word(32'h4000_0000 + 32'(sent)); sent++; end
    start = 1'b1; tick(); start = 1'b0;
    guard = 0;
    while (sent < 17 && guard < 100) begin
      in_valid = 1'b1;
      in_instr = 32'h4000_0000 + 32'(sent);
      acc = m_ready();
      tick();
      if (acc) sent++;
      guard++;
    end
    in_valid = 1'b0;
    chk("t5_sent",    32'(sent), 32'd17);
    repeat (6) tick();
    chk("t5_wrap",    32'(issued_cnt), 32'd1);
    end_run();

    // Asynchronous reset mid-run at occupancy 3
    for (int i = 0; i < 3; i++) push_word(32'h5000_0000 + 32'(i));
    start = 1'b1; tick(); start = 1'b0;
    tick();
    in_valid = 1'b1; in_instr = 32'h5000_0003;
    tick();
    in_valid = 1'b0;
    chk("t6_pre_iss", 32'(cpu_issue), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("t6_cpu_rst", 32'(cpu_rst),   32'd1);
    chk("t6_issue",   32'(cpu_issue), 32'd0);
    chk("t6_ready",   32'(in_ready),  32'd0);
    chk("t6_busy",    32'(busy),      32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    tick();
    chk("t6_rel_rst", 32'(cpu_rst),  32'd0);
    chk("t6_idle_rdy", 32'(in_ready), 32'd1);
    start = 1'b1; tick(); start = 1'b0;
    repeat (2) tick();
    chk("t6_empty",   32'(cpu_issue), 32'd0);
    chk("t6_empty_i", cpu_instr,      32'h0000_0013);
    tick();
    chk("t6_cnt",     32'(issued_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
